// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch (datapath) and refill (memory) channels of the instruction cache
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-block instruction cache with single-word refill
// Define ICACHE_STATS_EN to build the saturating hit/miss counters.
module icache #(
  parameter int SETS = 16
) (
  input logic     CLK,
  input logic     RST,
  icache_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, next_state;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];
  logic [31:0]      miss_addr;

  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic             lookup_hit, miss, fill;
  logic             unused_bits;

  assign idx         = bus.imemaddr[IDX_W+1:2];
  assign tag         = bus.imemaddr[31:IDX_W+2];
  assign fill_idx    = miss_addr[IDX_W+1:2];
  assign fill_tag    = miss_addr[31:IDX_W+2];
  assign lookup_hit  = bus.imemREN & valid[idx] & (tags[idx] == tag);
  assign unused_bits = ^bus.imemaddr[1:0];
  assign bus.iaddr   = miss_addr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.imemREN && !lookup_hit) next_state = FETCH;
      FETCH:   if (!bus.iwait) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    miss         = 1'b0;
    fill         = 1'b0;
    case (state)
      IDLE: begin
        bus.ihit = lookup_hit;
        if (lookup_hit) bus.imemload = data[idx];
        miss = bus.imemREN & ~lookup_hit;
      end
      FETCH: begin
        bus.iREN = 1'b1;
        fill     = ~bus.iwait;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      if (miss) miss_addr <= {bus.imemaddr[31:2], 2'b00};
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (bus.ihit && hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
      if (miss && misses_q != 32'hFFFF_FFFF)   misses_q <= misses_q + 32'd1;
    end
  end

  assign bus.hit_count  = hits_q;
  assign bus.miss_count = misses_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed-vector bench for icache (SETS=16)
module tb_icache;
  logic CLK = 1'b0;
  logic RST;
  int nvec = 0;
  int nmis = 0;
  logic [31:0] exp_hits, exp_miss;

  icache_if bus();
  icache #(.SETS(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
`ifdef ICACHE_STATS_EN
    exp_hits = 32'd3;
    exp_miss = 32'd3;
`else
    exp_hits = 32'd0;
    exp_miss = 32'd0;
`endif
    RST = 1'b1;
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iwait = 1'b1; bus.iload = '0;
    #2;
    chk("rst_ihit", bus.ihit, 0);
    chk("rst_imemload", bus.imemload, 0);
    chk("rst_iREN", bus.iREN, 0);
    chk("rst_iaddr", bus.iaddr, 0);
    chk("rst_hits", bus.hit_count, 0);
    chk("rst_miss", bus.miss_count, 0);
    tick(); RST = 1'b0;

    // Reset asserted mid-FETCH
    tick(); bus.imemREN = 1'b1; bus.imemaddr = 32'h0; #2;
    chk("t1_detect_ihit", bus.ihit, 0);
    tick(); #2;
    chk("t1_fetch_iREN", bus.iREN, 1);
    RST = 1'b1; bus.iwait = 1'b0; bus.iload = 32'hDEAD_BEEF; #1;
    chk("t1_async_iREN", bus.iREN, 0);
    chk("t1_async_iaddr", bus.iaddr, 0);
    tick();
    chk("t1_held_iREN", bus.iREN, 0);
    RST = 1'b0; bus.iwait = 1'b1; #2;
    chk("t1_refetch_ihit", bus.ihit, 0);
    chk("t1_refetch_iREN", bus.iREN, 0);
    tick(); bus.iwait = 1'b0; bus.iload = 32'h1234_5678; #2;
    chk("t1_iREN_next", bus.iREN, 1);
    chk("t1_fill_ihit", bus.ihit, 0);
    tick(); bus.iwait = 1'b1; #2;
    chk("t1_hit", bus.ihit, 1);
    chk("t1_data", bus.imemload, 32'h1234_5678);

    // Fresh reset so counters start from zero
    tick(); RST = 1'b1; bus.imemREN = 1'b0; #2;
    tick(); RST = 1'b0; #2;
    chk("t2_cnt_clear", bus.hit_count, 0);

    // Cold miss at 0x40, three wait cycles
    tick(); bus.imemREN = 1'b1; bus.imemaddr = 32'h40; #2;
    chk("t2_c0_ihit", bus.ihit, 0);
    chk("t2_c0_iREN", bus.iREN, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      chk("t2_wait_iREN", bus.iREN, 1);
      chk("t2_wait_iaddr", bus.iaddr, 32'h40);
      chk("t2_wait_ihit", bus.ihit, 0);
    end
    tick(); bus.iwait = 1'b0; bus.iload = 32'h2001_0005; #2;
    chk("t2_fill_iaddr", bus.iaddr, 32'h40);
    chk("t2_fill_ihit", bus.ihit, 0);
    tick(); bus.iwait = 1'b1; bus.iload = 32'h0; #2;
    chk("t2_c5_ihit", bus.ihit, 1);
    chk("t2_c5_data", bus.imemload, 32'h2001_0005);
    chk("t2_c5_iREN", bus.iREN, 0);

    // Idle cycle, then repeat fetch of 0x40
    tick(); bus.imemREN = 1'b0; #2;
    chk("t3_idle_ihit", bus.ihit, 0);
    chk("t3_idle_load", bus.imemload, 0);
    tick(); bus.imemREN = 1'b1; #2;
    chk("t3_hit", bus.ihit, 1);
    chk("t3_data", bus.imemload, 32'h2001_0005);

    // 0x80 shares set 0 with 0x40
    tick(); bus.imemaddr = 32'h80; #2;
    chk("t4_80_miss", bus.ihit, 0);
    tick(); #2;
    chk("t4_80_iaddr", bus.iaddr, 32'h80);
    bus.iwait = 1'b0; bus.iload = 32'h8C01_0080;
    tick(); bus.iwait = 1'b1; #2;
    chk("t4_80_hit", bus.ihit, 1);
    chk("t4_80_data", bus.imemload, 32'h8C01_0080);
    tick(); bus.imemaddr = 32'h40; #2;
    chk("t4_40_miss", bus.ihit, 0);
    tick(); bus.iwait = 1'b0; bus.iload = 32'h2001_0005; #2;
    chk("t4_40_iaddr", bus.iaddr, 32'h40);
    tick(); bus.iwait = 1'b1; bus.imemREN = 1'b0; #2;
    chk("t6_hits", bus.hit_count, exp_hits);
    chk("t6_miss", bus.miss_count, exp_miss);
    tick(); bus.imemREN = 1'b1; #2;
    chk("t4_40_rehit", bus.ihit, 1);

    // Redirect mid-FETCH: 0x100 and 0x200 both index set 0
    tick(); bus.imemaddr = 32'h100; #2;
    chk("t5_100_miss", bus.ihit, 0);
    tick(); bus.imemaddr = 32'h200; #2;
    chk("t5_keep_iaddr", bus.iaddr, 32'h100);
    tick(); bus.iwait = 1'b0; bus.iload = 32'h0000_0100; #2;
    chk("t5_fill_ihit", bus.ihit, 0);
    chk("t5_fill_iaddr", bus.iaddr, 32'h100);
    tick(); bus.iwait = 1'b1; #2;
    chk("t5_200_miss", bus.ihit, 0);
    tick(); #2;
    chk("t5_200_iREN", bus.iREN, 1);
    chk("t5_200_iaddr", bus.iaddr, 32'h200);
    bus.iwait = 1'b0; bus.iload = 32'h0000_0200;
    tick(); bus.iwait = 1'b1; #2;
    chk("t5_200_hit", bus.ihit, 1);
    chk("t5_200_data", bus.imemload, 32'h0000_0200);
    tick(); bus.imemaddr = 32'h100; #2;
    chk("t5_100_evicted", bus.ihit, 0);

    // Request drops during FETCH; refill of 0x100 still lands
    tick(); bus.imemREN = 1'b0; bus.imemaddr = 32'h44; #2;
    chk("t5b_iaddr", bus.iaddr, 32'h100);
    tick(); bus.iwait = 1'b0; bus.iload = 32'hABCD_0100; #2;
    chk("t5b_fill_iREN", bus.iREN, 1);
    tick(); bus.iwait = 1'b1; #2;
    chk("t5b_idle_iREN", bus.iREN, 0);
    tick(); bus.imemREN = 1'b1; bus.imemaddr = 32'h100; #2;
    chk("t5b_100_hit", bus.ihit, 1);
    chk("t5b_100_data", bus.imemload, 32'hABCD_0100);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
